mode_reg: RTL and testbench
===========================

# mode_reg

Parametrised general-purpose datapath register, the successor to the processor's fixed 16-bit enable-load data register. Besides parallel load, it supports clear, logical and arithmetic shifts with serial in/out, and increment/decrement with carry/borrow, all in one cycle. It serves as the working register for multiply/divide sequencing (accumulator/quotient shifting), loop counters and address stepping. All state is held in per-bit flip-flop slices with enable, clocked on `clk`.

## Interface
- `W`, 16: register width in bits; legal values are W ≥ 2.
- `RST_VAL`, 0: W-bit value loaded into `out` on reset.

- `clk`  in  1: rising-edge clock.
- `rst_b`  in  1: reset; asynchronous, active-low.
- `en`  in  1: operation enable. When 0, all state holds regardless of `op`.
- `op`  in  3: operation select (encoding under Operation).
- `in`  in  W: parallel load data.
- `sin`  in  1: serial input bit for SHL/SHR.
- `out`  out  W: register contents.
- `sout`  out  1: registered bit shifted out by the last shift.
- `cout`  out  1: registered carry/borrow from the last INC/DEC.
- `zero`  out  1: combinational flag, `out == 0`.

## Operation
- Reset (`rst_b` = 0): `out` = RST_VAL, `sout` = 0, `cout` = 0. This takes effect immediately, independent of `clk`, and overrides `en`/`op`.
- With `en` = 1, `op` selects the update applied at the rising edge:
  - 000 HOLD: no change to `out`, `sout` or `cout`.
  - 001 LOAD: `out` ← `in`; `sout` ← 0; `cout` ← 0.
  - 010 CLR: `out` ← 0; `sout` ← 0; `cout` ← 0.
  - 011 SHL: `out` ← {out[W-2:0], sin}; `sout` ← out[W-1]; `cout` holds.
  - 100 SHR: `out` ← {sin, out[W-1:1]}; `sout` ← out[0]; `cout` holds.
  - 101 ASR: `out` ← {out[W-1], out[W-1:1]}; `sout` ← out[0]; `cout` holds. `sin` is ignored.
  - 110 INC: `out` ← (out + 1) mod 2^W; `cout` ← 1 iff the old `out` was all ones; `sout` holds.
  - 111 DEC: `out` ← (out − 1) mod 2^W; `cout` ← 1 iff the old `out` was 0 (borrow); `sout` holds.
- Arithmetic is unsigned and modulo 2^W. Wrap-around is flagged only through `cout`.
- `zero` follows `out` combinationally, including during reset (it is 1 when RST_VAL = 0).
- `in` and `sin` are ignored by every op that does not name them.

## Timing
- Every op has 1-cycle latency: the result is visible on `out`/`sout`/`cout` after the rising edge where `en` = 1.
- There is no handshake and no multi-cycle state. Back-to-back ops on consecutive cycles are legal, and each uses the previous cycle's `out`.
- `en` = 0 on an edge: all three registers hold, including `sout` and `cout`.
- `rst_b` asserted mid-cycle: outputs take reset values without waiting for a clock edge.
- `rst_b` deasserted: the first update happens at the next rising edge with `en` = 1. Deassertion is driven synchronously to `clk` by the reset generator.
- `op` encodings are fully decoded, so no value is undefined.

## Structure
- Shared processor package holds the `op` encoding constants: OP_HOLD, OP_LOAD, OP_CLR, OP_SHL, OP_SHR, OP_ASR, OP_INC, OP_DEC. The control unit uses the same constants.
- Sub-module `reg_slice`: one bit cell containing a mode mux plus the existing enable flip-flop.
  - Data inputs: left neighbour, right neighbour, load bit, carry-in/borrow-in.
  - Outputs: q and carry-out.
  - Instantiated W times with a generate loop.
  - The carry chain is rippled between slices. Bit 0 receives carry-in = 1 for INC/DEC.
- `sout`/`cout` flip-flops and the `zero` reduction live in the `mode_reg` top.

## Test plan
- Reset: instance with RST_VAL = 16'h00FF, load 16'h1234, then pulse `rst_b` low mid-cycle → `out` = 16'h00FF, `sout` = 0, `cout` = 0 before the next edge; `zero` = 0.
- Load/enable: en = 1, LOAD 16'hA5C3 → `out` = 16'hA5C3 next cycle. Then en = 0, op = LOAD, in = 16'h1234 for 3 cycles → `out` stays 16'hA5C3. CLR → `out` = 0, `zero` = 1.
- Shifts: `out` = 16'h8001.
  - SHL with sin = 0 → 16'h0002, `sout` = 1.
  - SHR with sin = 1 → 16'h8001, `sout` = 0.
  - HOLD → `sout` stays 0.
- Arithmetic shift: `out` = 16'h8000, ASR with sin = 0 → 16'hC000. After 15 ASR total → 16'hFFFF. A 16th ASR → 16'hFFFF with `sout` = 1.
- Inc/dec wrap:
  - 16'hFFFF INC → 16'h0000, `cout` = 1, `zero` = 1.
  - INC again → 16'h0001, `cout` = 0.
  - DEC → 16'h0000, `cout` = 0.
  - DEC → 16'hFFFF, `cout` = 1.
  - SHL → `cout` stays 1.
- Width sweep: W = 2, 8, 32 with a random op/en stream (≥ 10k cycles) → matches the reference model every cycle on `out`, `sout`, `cout`, `zero`.

Source files
------------

// File: rtl/mode_reg_pkg.sv
// Shared operation encodings for the datapath working register and the control unit.
package mode_reg_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_ASR  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

  // INC/DEC are the only ops that use the rippled carry/borrow chain.
  function automatic logic is_arith(input op_e op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/reg_slice.sv
// One bit of the working register: mode mux in front of an enable flip-flop.
module reg_slice
  import mode_reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en_i,
  input  op_e  op_i,
  input  logic left_i,
  input  logic right_i,
  input  logic load_i,
  input  logic ci_i,
  output logic q_o,
  output logic co_c
);

  logic q_d, q_q;

  // Next bit and carry/borrow out; borrow propagates through zeros on DEC.
  always_comb begin
    q_d  = q_q;
    co_c = 1'b0;
    case (op_i)
      OP_HOLD: q_d = q_q;
      OP_LOAD: q_d = load_i;
      OP_CLR:  q_d = 1'b0;
      OP_SHL:  q_d = right_i;
      OP_SHR,
      OP_ASR:  q_d = left_i;
      OP_INC: begin
        q_d  = q_q ^ ci_i;
        co_c = q_q & ci_i;
      end
      OP_DEC: begin
        q_d  = q_q ^ ci_i;
        co_c = ~q_q & ci_i;
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_q <= RST_BIT;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mode_reg.sv
// Parametrised working register: load/clear/shift/inc/dec in one cycle, built from per-bit slices.
module mode_reg
  import mode_reg_pkg::*;
#(
  parameter int unsigned   W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            en,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    in,
  input  logic            sin,
  output logic [W-1:0]    out,
  output logic            sout,
  output logic            cout,
  output logic            zero
);

  op_e          op_s;
  logic [W-1:0] q;
  logic [W:0]   carry;
  logic         msb_in;
  logic         sout_d, sout_q;
  logic         cout_d, cout_q;

  assign op_s     = op_e'(op);
  assign carry[0] = is_arith(op_s);
  // ASR replicates the sign bit; SHR feeds the serial input into the MSB.
  assign msb_in   = (op_s == OP_ASR) ? q[W-1] : sin;

  for (genvar i = 0; i < int'(W); i++) begin : g_slice
    logic left_b, right_b;

    if (i == int'(W) - 1) begin : g_msb
      assign left_b = msb_in;
    end else begin : g_mid_l
      assign left_b = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign right_b = sin;
    end else begin : g_mid_r
      assign right_b = q[i-1];
    end

    reg_slice #(
      .RST_BIT (RST_VAL[i])
    ) u_slice (
      .clk     (clk),
      .rst_b   (rst_b),
      .en_i    (en),
      .op_i    (op_s),
      .left_i  (left_b),
      .right_i (right_b),
      .load_i  (in[i]),
      .ci_i    (carry[i]),
      .q_o     (q[i]),
      .co_c    (carry[i+1])
    );
  end

  // Side flags: shifts update sout, INC/DEC update cout, LOAD/CLR clear both.
  always_comb begin
    sout_d = sout_q;
    cout_d = cout_q;
    case (op_s)
      OP_LOAD,
      OP_CLR: begin
        sout_d = 1'b0;
        cout_d = 1'b0;
      end
      OP_SHL:  sout_d = q[W-1];
      OP_SHR,
      OP_ASR:  sout_d = q[0];
      OP_INC,
      OP_DEC:  cout_d = carry[W];
      default: begin
        sout_d = sout_q;
        cout_d = cout_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sout_q <= 1'b0;
      cout_q <= 1'b0;
    end else if (en) begin
      sout_q <= sout_d;
      cout_q <= cout_d;
    end
  end

  assign out  = q;
  assign sout = sout_q;
  assign cout = cout_q;
  assign zero = (q == '0);

endmodule

// File: tb/tb_mode_reg.sv
// Directed checks on a 16-bit instance plus a randomized width sweep against a behavioural model.
module tb_mode_reg;
  import mode_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        en;
  logic [2:0]  op;
  logic [15:0] d_in;
  logic        sin;
  logic [15:0] out16;
  logic        sout16, cout16, zero16;

  mode_reg #(.W(16), .RST_VAL(16'h00FF)) dut16 (
    .clk(clk), .rst_b(rst_b), .en(en), .op(op), .in(d_in), .sin(sin),
    .out(out16), .sout(sout16), .cout(cout16), .zero(zero16)
  );

  logic        rst_sw_b;
  logic        sw_en  [3];
  logic [2:0]  sw_op  [3];
  logic [31:0] sw_in  [3];
  logic        sw_sin [3];
  logic [1:0]  o2;
  logic [7:0]  o8;
  logic [31:0] o32;
  logic        s2, s8, s32, c2, c8, c32, z2, z8, z32;

  mode_reg #(.W(2), .RST_VAL(2'b10)) dut2 (
    .clk(clk), .rst_b(rst_sw_b), .en(sw_en[0]), .op(sw_op[0]), .in(sw_in[0][1:0]),
    .sin(sw_sin[0]), .out(o2), .sout(s2), .cout(c2), .zero(z2)
  );
  mode_reg #(.W(8), .RST_VAL(8'h5A)) dut8 (
    .clk(clk), .rst_b(rst_sw_b), .en(sw_en[1]), .op(sw_op[1]), .in(sw_in[1][7:0]),
    .sin(sw_sin[1]), .out(o8), .sout(s8), .cout(c8), .zero(z8)
  );
  mode_reg #(.W(32), .RST_VAL(32'hDEADBEEF)) dut32 (
    .clk(clk), .rst_b(rst_sw_b), .en(sw_en[2]), .op(sw_op[2]), .in(sw_in[2]),
    .sin(sw_sin[2]), .out(o32), .sout(s32), .cout(c32), .zero(z32)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] eo, input logic es,
                       input logic ec, input logic ez);
    check({tag, ".out"},  32'(out16),  32'(eo));
    check({tag, ".sout"}, 32'(sout16), 32'(es));
    check({tag, ".cout"}, 32'(cout16), 32'(ec));
    check({tag, ".zero"}, 32'(zero16), 32'(ez));
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic e, input logic [2:0] o, input logic [15:0] d, input logic s);
    en = e; op = o; d_in = d; sin = s;
    @(negedge clk);
  endtask

  task automatic model_step(input int w, input logic e, input logic [2:0] o,
                            input logic [31:0] d, input logic si,
                            input logic [31:0] mo_i, input logic ms_i, input logic mc_i,
                            output logic [31:0] mo, output logic ms, output logic mc);
    logic [31:0] m;
    logic        top;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    mo  = mo_i; ms = ms_i; mc = mc_i;
    top = mo_i[w-1];
    if (e) begin
      case (o)
        3'd1: begin mo = d & m; ms = 1'b0; mc = 1'b0; end
        3'd2: begin mo = 32'd0; ms = 1'b0; mc = 1'b0; end
        3'd3: begin ms = top;      mo = ((mo_i << 1) | 32'(si)) & m; end
        3'd4: begin ms = mo_i[0];  mo = (mo_i >> 1) | (32'(si) << (w - 1)); end
        3'd5: begin ms = mo_i[0];  mo = (mo_i >> 1) | (32'(top) << (w - 1)); end
        3'd6: begin mc = (mo_i == m);     mo = (mo_i + 32'd1) & m; end
        3'd7: begin mc = (mo_i == 32'd0); mo = (mo_i - 32'd1) & m; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] sw_q(input int k);
    case (k)
      0:       return 32'(o2);
      1:       return 32'(o8);
      default: return o32;
    endcase
  endfunction

  function automatic logic [2:0] sw_flags(input int k);
    case (k)
      0:       return {s2, c2, z2};
      1:       return {s8, c8, z8};
      default: return {s32, c32, z32};
    endcase
  endfunction

  int          wv   [3] = '{2, 8, 32};
  logic [31:0] rstv [3] = '{32'h2, 32'h5A, 32'hDEADBEEF};
  logic [31:0] m_out[3];
  logic        m_sout[3], m_cout[3];

  initial begin
    rst_b = 1'b0; rst_sw_b = 1'b0;
    en = 1'b0; op = 3'd0; d_in = 16'h0; sin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sw_en[k] = 1'b0; sw_op[k] = 3'd0; sw_in[k] = 32'd0; sw_sin[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk16("reset", 16'h00FF, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1; rst_sw_b = 1'b1;
    @(negedge clk);
    chk16("post_reset_idle", 16'h00FF, 1'b0, 1'b0, 1'b0);

    // Build non-zero sout/cout, then reset mid-cycle
    step(1'b1, 3'd1, 16'h8000, 1'b0); chk16("load8000", 16'h8000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 16'hFFFF, 1'b0); chk16("shl_to0",  16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'd7, 16'h0000, 1'b1); chk16("dec_wrap", 16'hFFFF, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd1, 16'h1234, 1'b0); chk16("load1234", 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 16'h0000, 1'b0); chk16("dec1234",  16'h1233, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 16'h0000, 1'b1); chk16("shl1233",  16'h2467, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 16'hFFFF, 1'b0);
    step(1'b1, 3'd6, 16'h0000, 1'b0); chk16("inc_ffff_a", 16'h0000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 3'd1, 16'h1234, 1'b0);
    en = 1'b1; op = 3'd6;
    #1 rst_b = 1'b0;
    #1 chk16("async_reset", 16'h00FF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("reset_held", 16'h00FF, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;

    // Load and enable gating
    step(1'b1, 3'd1, 16'hA5C3, 1'b0); chk16("loadA5C3", 16'hA5C3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd1, 16'h1234, 1'b1); chk16($sformatf("en0_hold%0d", i), 16'hA5C3, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 3'd2, 16'hFFFF, 1'b1); chk16("clr", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Logical shifts
    step(1'b1, 3'd1, 16'h8001, 1'b0);
    step(1'b1, 3'd3, 16'hFFFF, 1'b0); chk16("shl8001", 16'h0002, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd4, 16'h0000, 1'b1); chk16("en0_shr", 16'h0002, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd4, 16'h0000, 1'b1); chk16("shr_sin1", 16'h8001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 16'hFFFF, 1'b1); chk16("hold", 16'h8001, 1'b0, 1'b0, 1'b0);

    // Arithmetic shift right saturates to all ones
    step(1'b1, 3'd1, 16'h8000, 1'b0);
    step(1'b1, 3'd5, 16'h0000, 1'b0); chk16("asr1", 16'hC000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, 16'h0000, 1'b1); chk16("asr2_sin_ign", 16'hE000, 1'b0, 1'b0, 1'b0);
    repeat (13) step(1'b1, 3'd5, 16'h0000, 1'b0);
    chk16("asr15", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, 16'h0000, 1'b0); chk16("asr16", 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Increment/decrement wrap
    step(1'b1, 3'd6, 16'h0000, 1'b0); chk16("inc_wrap", 16'h0000, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'd6, 16'h0000, 1'b0); chk16("inc_1",    16'h0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 16'h0000, 1'b0); chk16("dec_0",    16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'd7, 16'h0000, 1'b0); chk16("dec_wrap2", 16'hFFFF, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd6, 16'h0000, 1'b0); chk16("en0_inc",  16'hFFFF, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd3, 16'h0000, 1'b0); chk16("shl_cout_hold", 16'hFFFE, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd7, 16'h0000, 1'b0); chk16("dec_mid", 16'hFFFD, 1'b1, 1'b0, 1'b0);

    // Randomized width sweep; the sweep instances sat idle since reset
    for (int k = 0; k < 3; k++) begin
      m_out[k] = rstv[k]; m_sout[k] = 1'b0; m_cout[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        logic [2:0] f;
        f = sw_flags(k);
        check($sformatf("w%0d.out@%0d",  wv[k], cyc), sw_q(k), m_out[k]);
        check($sformatf("w%0d.sout@%0d", wv[k], cyc), 32'(f[2]), 32'(m_sout[k]));
        check($sformatf("w%0d.cout@%0d", wv[k], cyc), 32'(f[1]), 32'(m_cout[k]));
        check($sformatf("w%0d.zero@%0d", wv[k], cyc), 32'(f[0]), 32'(m_out[k] == 32'd0));
      end
      for (int k = 0; k < 3; k++) begin
        logic [31:0] no;
        logic        ns, nc;
        sw_en[k]  = ($urandom_range(0, 9) != 0);
        sw_op[k]  = 3'($urandom_range(0, 7));
        sw_in[k]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        sw_sin[k] = 1'($urandom_range(0, 1));
        model_step(wv[k], sw_en[k], sw_op[k], sw_in[k], sw_sin[k],
                   m_out[k], m_sout[k], m_cout[k], no, ns, nc);
        m_out[k] = no; m_sout[k] = ns; m_cout[k] = nc;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
